// File: rtl/sr_latch_bank_arbiter.sv
// ============================================================================
// Module      : sr_latch_bank_arbiter
// Description : Round-robin arbiter sharing one gated SR latch between
//               N_REQ requesters. Drives a setup / gate / hold sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_latch_bank_arbiter #(
  parameter int N_REQ    = 4,
  parameter int GATE_CYC = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_s,
  input  logic [N_REQ-1:0] req_r,
  output logic [N_REQ-1:0] gnt,
  output logic             done,
  output logic             err,
  output logic             lat_s,
  output logic             lat_r,
  output logic             lat_g,
  output logic             busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (GATE_CYC > 1) ? $clog2(GATE_CYC) : 1;
  localparam logic [PW-1:0]    C_LAST    = PW'(N_REQ - 1);
  localparam logic [CW-1:0]    C_GATE_LD = CW'(GATE_CYC - 1);
  localparam logic [N_REQ-1:0] C_ONE     = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_GATE   = 3'd2,
    S_HOLD   = 3'd3,
    S_REJECT = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    w_ptr_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [N_REQ-1:0] w_gnt_nxt;
  logic             w_s_nxt;
  logic             w_r_nxt;

  logic             w_found;
  logic [PW-1:0]    w_win;
  logic [PW:0]      w_sum;

  // Scan requesters starting at the pointer, wrapping past the last index.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(i);
      if (w_sum >= (PW+1)'(N_REQ)) begin
        w_sum = w_sum - (PW+1)'(N_REQ);
      end
      if (!w_found && req[w_sum[PW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_sum[PW-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_gnt_nxt   = gnt;
    w_s_nxt     = lat_s;
    w_r_nxt     = lat_r;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_gnt_nxt = C_ONE << w_win;
          w_ptr_nxt = (w_win == C_LAST) ? '0 : w_win + 1'b1;
          // S=R=1 is never loaded onto the latch pins.
          if (req_s[w_win] && req_r[w_win]) begin
            w_state_nxt = S_REJECT;
          end else begin
            w_s_nxt     = req_s[w_win];
            w_r_nxt     = req_r[w_win];
            w_state_nxt = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        w_cnt_nxt   = C_GATE_LD;
        w_state_nxt = S_GATE;
      end
      S_GATE: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_HOLD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_HOLD: begin
        w_gnt_nxt   = '0;
        w_s_nxt     = 1'b0;
        w_r_nxt     = 1'b0;
        w_state_nxt = S_IDLE;
      end
      S_REJECT: begin
        w_gnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_gnt_nxt   = '0;
        w_s_nxt     = 1'b0;
        w_r_nxt     = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so every pin comes from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_cnt   <= '0;
      gnt     <= '0;
      lat_s   <= 1'b0;
      lat_r   <= 1'b0;
      lat_g   <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      busy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      gnt     <= w_gnt_nxt;
      lat_s   <= w_s_nxt;
      lat_r   <= w_r_nxt;
      lat_g   <= (w_state_nxt == S_GATE);
      done    <= (w_state_nxt == S_HOLD) || (w_state_nxt == S_REJECT);
      err     <= (w_state_nxt == S_REJECT);
      busy    <= (w_state_nxt != S_IDLE);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sr_latch_bank_arbiter.sv
// ============================================================================
// Module      : tb_sr_latch_bank_arbiter
// Description : Bench for sr_latch_bank_arbiter with a transaction-timeline
//               reference model and a behavioural gated SR latch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sr_latch_bank_arbiter;

  localparam int N  = 4;
  localparam int GC = 2;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req   = '0;
  logic [N-1:0] req_s = '0;
  logic [N-1:0] req_r = '0;
  logic [N-1:0] gnt;
  logic         done, err, lat_s, lat_r, lat_g, busy;

  always #5 clk = ~clk;

  sr_latch_bank_arbiter #(.N_REQ(N), .GATE_CYC(GC)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_s(req_s), .req_r(req_r),
    .gnt(gnt), .done(done), .err(err), .lat_s(lat_s), .lat_r(lat_r),
    .lat_g(lat_g), .busy(busy)
  );

  // The shared latch, driven by the arbiter.
  logic tb_q = 1'b0;
  always @(lat_s or lat_r or lat_g) begin
    if (lat_g) begin
      if (lat_s && !lat_r) tb_q = 1'b1;
      else if (lat_r && !lat_s) tb_q = 1'b0;
    end
  end

  typedef struct packed {
    logic [N-1:0] gnt;
    logic done, err, s, r, g, busy;
  } exp_t;

  exp_t q[$];
  int   m_ptr = 0;
  logic m_lat = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   glog[$];
  int   dlog[$];
  int   cnum = 0;
  bit   rr_mode = 0, rand_mode = 0, flip_mode = 0;
  logic prev_s = 0, prev_r = 0, prev_g = 0;

  function automatic exp_t mk(logic [N-1:0] g1, logic d, logic e, logic s,
                              logic r, logic g, logic b);
    exp_t x;
    x.gnt = g1; x.done = d; x.err = e; x.s = s; x.r = r; x.g = g; x.busy = b;
    return x;
  endfunction

  function automatic int oh2i(logic [N-1:0] v);
    int k = -1;
    for (int i = 0; i < N; i++) if (v[i]) k = i;
    return k;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Transaction timeline: one entry per cycle of expected outputs after a grant.
  task automatic model_edge(output exp_t e);
    logic [N-1:0] oh;
    logic s, r;
    int w;
    if (q.size() == 0 && req != '0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
      m_ptr = (w + 1) % N;
      oh = '0;
      oh[w] = 1'b1;
      s = req_s[w];
      r = req_r[w];
      if (s && r) begin
        q.push_back(mk(oh, 1, 1, 0, 0, 0, 1));
      end else begin
        q.push_back(mk(oh, 0, 0, s, r, 0, 1));
        repeat (GC) q.push_back(mk(oh, 0, 0, s, r, 1, 1));
        q.push_back(mk(oh, 1, 0, s, r, 0, 1));
        if (s) m_lat = 1'b1;
        else if (r) m_lat = 1'b0;
      end
      q.push_back('0);
    end
    if (q.size() != 0) e = q.pop_front();
    else e = '0;
  endtask

  task automatic raise(input int i, input bit legal_only);
    int v;
    v = $urandom_range(legal_only ? 1 : 0, 7);
    req[i]   = 1'b1;
    req_s[i] = (v == 0) ? 1'b1 : v[0];
    req_r[i] = (v == 0) ? 1'b1 : (!v[0] && v[1]);
  endtask

  task automatic requesters();
    for (int i = 0; i < N; i++) begin
      if (done && gnt[i]) begin
        req[i] = 1'b0; req_s[i] = 1'b0; req_r[i] = 1'b0;
      end
    end
    if (flip_mode && lat_g) begin
      for (int i = 0; i < N; i++) begin
        if (gnt[i] && $urandom_range(0, 1) == 1) begin
          req_s[i] = ~req_s[i];
          req_r[i] = 1'($urandom_range(0, 1));
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!req[i] && (rr_mode || (rand_mode && $urandom_range(0, 3) == 0)))
        raise(i, rr_mode);
    end
  endtask

  task automatic cycle();
    exp_t e;
    @(posedge clk);
    model_edge(e);
    #1;
    cnum++;
    check("gnt",   32'(gnt),   32'(e.gnt));
    check("done",  32'(done),  32'(e.done));
    check("err",   32'(err),   32'(e.err));
    check("lat_s", 32'(lat_s), 32'(e.s));
    check("lat_r", 32'(lat_r), 32'(e.r));
    check("lat_g", 32'(lat_g), 32'(e.g));
    check("busy",  32'(busy),  32'(e.busy));
    if (lat_g) check("no_sr_overlap", 32'(lat_s & lat_r), 32'd0);
    if (lat_g || prev_g) check("sr_stable", 32'({lat_s, lat_r}), 32'({prev_s, prev_r}));
    prev_s = lat_s; prev_r = lat_r; prev_g = lat_g;
    if (done) begin
      glog.push_back(oh2i(gnt));
      dlog.push_back(cnum);
      check("latch_q", 32'(tb_q), 32'(m_lat));
    end
    requesters();
  endtask

  task automatic drain();
    int c = 0;
    while (c < 300 && (req != '0 || busy)) begin
      cycle();
      c++;
    end
    check("drain_idle", 32'(req == '0 && !busy), 32'd1);
    cycle();
  endtask

  task automatic check_zero_outputs(input string pfx);
    check({pfx, "_gnt"},   32'(gnt),   32'd0);
    check({pfx, "_done"},  32'(done),  32'd0);
    check({pfx, "_err"},   32'(err),   32'd0);
    check({pfx, "_lat_s"}, 32'(lat_s), 32'd0);
    check({pfx, "_lat_r"}, 32'(lat_r), 32'd0);
    check({pfx, "_lat_g"}, 32'(lat_g), 32'd0);
    check({pfx, "_busy"},  32'(busy),  32'd0);
  endtask

  initial begin
    int k, gcnt;
    bit seen;

    repeat (2) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;
    cycle();

    // Round robin: all four requesting continuously.
    rr_mode = 1;
    for (int i = 0; i < N; i++) raise(i, 1);
    glog.delete();
    k = 0;
    while (k < 200 && glog.size() < 5) begin cycle(); k++; end
    rr_mode = 0;
    check("rr_count", 32'(glog.size()), 32'd5);
    if (glog.size() >= 5)
      for (int j = 0; j < 5; j++) check("rr_order", 32'(glog[j]), 32'(j % 4));
    drain();

    // Single set on requester 0.
    req = 4'b0001; req_s = 4'b0001; req_r = 4'b0000;
    k = 0; gcnt = 0; seen = 0;
    while (k < 20 && !seen) begin
      cycle(); k++;
      if (lat_g) gcnt++;
      if (done) seen = 1;
    end
    check("set_latency", 32'(k), 32'(GC + 2));
    check("set_gate_width", 32'(gcnt), 32'(GC));
    check("set_q", 32'(tb_q), 32'd1);
    drain();

    // Illegal S=R=1 on requester 2.
    req = 4'b0100; req_s = 4'b0100; req_r = 4'b0100;
    k = 0; gcnt = 0; seen = 0;
    while (k < 20 && !seen) begin
      cycle(); k++;
      if (lat_g) gcnt++;
      if (done) begin
        seen = 1;
        check("ill_err", 32'(err), 32'd1);
        check("ill_gnt", 32'(gnt), 32'h4);
      end
    end
    check("ill_latency", 32'(k), 32'd1);
    check("ill_no_gate", 32'(gcnt), 32'd0);
    check("ill_q_kept", 32'(tb_q), 32'd1);
    drain();

    // Contention: requester 2 arrives while requester 0 is in flight.
    glog.delete(); dlog.delete();
    req = 4'b0001; req_s = 4'b0000; req_r = 4'b0001;
    cycle(); cycle();
    req[2] = 1'b1; req_s[2] = 1'b1; req_r[2] = 1'b0;
    k = 0;
    while (k < 40 && glog.size() < 2) begin cycle(); k++; end
    check("cont_count", 32'(glog.size()), 32'd2);
    if (glog.size() >= 2) begin
      check("cont_first", 32'(glog[0]), 32'd0);
      check("cont_second", 32'(glog[1]), 32'd2);
      check("cont_gap", 32'(dlog[1] - dlog[0]), 32'(GC + 3));
    end
    check("cont_q", 32'(tb_q), 32'd1);
    drain();

    // Command bits flipped during the gate pulse must not reach the latch.
    req = 4'b1000; req_s = 4'b0000; req_r = 4'b1000;
    flip_mode = 1;
    k = 0; seen = 0;
    while (k < 20 && !seen) begin
      cycle(); k++;
      if (done) seen = 1;
    end
    flip_mode = 0;
    check("flip_done", 32'(seen), 32'd1);
    check("flip_q", 32'(tb_q), 32'd0);
    drain();

    // Randomised traffic.
    rand_mode = 1; flip_mode = 1;
    repeat (400) cycle();
    rand_mode = 0; flip_mode = 0;
    drain();

    // Asynchronous reset in the middle of a gate pulse.
    req = 4'b0010; req_s = 4'b0010; req_r = 4'b0000;
    k = 0;
    while (k < 20 && !lat_g) begin cycle(); k++; end
    check("rst_wait_gate", 32'(lat_g), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("async_rst");
    q.delete(); m_ptr = 0;
    req = '0; req_s = '0; req_r = '0;
    prev_s = 0; prev_r = 0; prev_g = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_q_held", 32'(tb_q), 32'd1);

    // Pointer must be back at 0: requesters 1 and 2 pending, 1 wins.
    glog.delete();
    req = 4'b0110; req_s = 4'b0000; req_r = 4'b0110;
    k = 0;
    while (k < 40 && glog.size() < 1) begin cycle(); k++; end
    check("ptr_reset_count", 32'(glog.size()), 32'd1);
    if (glog.size() >= 1) check("ptr_reset_first", 32'(glog[0]), 32'd1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
